config_loader: RTL and testbench

- Upstream feeder for the configuration shift-register chain.
- Accepts configuration words from a bitstream source over a valid/ready handshake, serialises them MSB-first onto the chain's serial input, and holds config_en high for exactly CHAIN_LENGTH clocks.
- Then drops config_en. The falling edge makes every chain stage transfer its shift contents to its config memory.
- On underrun or abort it flushes the chain with zeros, giving an all-unconfigured fabric, and flags an error.

---
 rtl/config_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_config_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Feeds the configuration daisy chain: buffers bitstream words, shifts them out MSB-first
// with config_en held for exactly CHAIN_LENGTH clocks, and flushes zeros on underrun/abort.
module config_loader #(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = 650,
    parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  config_clk,
    input  logic                  config_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_data,
    output logic                  config_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  bit_count
);

    localparam int WORDS_NEEDED = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int WCNT_WIDTH   = $clog2(WORDS_NEEDED + 1);
    localparam int AVAIL_WIDTH  = $clog2(WORD_WIDTH + 1);

    localparam logic [CNT_WIDTH-1:0]   LAST_BIT   = CNT_WIDTH'(CHAIN_LENGTH - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1'b1);
    localparam logic [WCNT_WIDTH-1:0]  WORDS_MAX  = WCNT_WIDTH'(WORDS_NEEDED);
    localparam logic [WCNT_WIDTH-1:0]  WCNT_ZERO  = {WCNT_WIDTH{1'b0}};
    localparam logic [WCNT_WIDTH-1:0]  WCNT_ONE   = WCNT_WIDTH'(1'b1);
    localparam logic [AVAIL_WIDTH-1:0] AVAIL_FULL = AVAIL_WIDTH'(WORD_WIDTH);
    localparam logic [AVAIL_WIDTH-1:0] AVAIL_MOVE = AVAIL_WIDTH'(WORD_WIDTH - 1);
    localparam logic [AVAIL_WIDTH-1:0] AVAIL_ZERO = {AVAIL_WIDTH{1'b0}};
    localparam logic [AVAIL_WIDTH-1:0] AVAIL_ONE  = AVAIL_WIDTH'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_LATCH = 3'd4
    } state_t;

    state_t                  state_r,      state_s;
    logic [WORD_WIDTH-1:0]   shift_word_r, shift_word_s;
    logic [AVAIL_WIDTH-1:0]  avail_r,      avail_s;
    logic [WORD_WIDTH-1:0]   pref_word_r,  pref_word_s;
    logic                    pref_valid_r, pref_valid_s;
    logic [WCNT_WIDTH-1:0]   words_r,      words_s;
    logic                    data_r,       data_s;
    logic                    en_r,         en_s;
    logic                    ready_r,      ready_s;
    logic [CNT_WIDTH-1:0]    count_r,      count_s;
    logic                    done_r,       done_s;
    logic                    err_r,        err_s;
    logic                    accept_s;

    assign accept_s = word_valid & ready_r;

    // Next-state, buffer movement and next registered-output values.
    always_comb begin
        state_s      = state_r;
        shift_word_s = shift_word_r;
        avail_s      = avail_r;
        pref_word_s  = pref_word_r;
        pref_valid_s = pref_valid_r;
        words_s      = words_r;
        data_s       = 1'b0;
        en_s         = 1'b0;
        count_s      = count_r;
        done_s       = done_r;
        err_s        = err_r;
        ready_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s      = ST_PRIME;
                    done_s       = 1'b0;
                    err_s        = 1'b0;
                    count_s      = CNT_ZERO;
                    words_s      = WCNT_ZERO;
                    avail_s      = AVAIL_ZERO;
                    pref_valid_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (abort) begin
                    state_s      = ST_FLUSH;
                    err_s        = 1'b1;
                    count_s      = CNT_ZERO;
                    pref_valid_s = 1'b0;
                    avail_s      = AVAIL_ZERO;
                end else begin
                    if (avail_r == AVAIL_ZERO && pref_valid_r) begin
                        shift_word_s = pref_word_r;
                        avail_s      = AVAIL_FULL;
                        pref_valid_s = 1'b0;
                        state_s      = ST_SHIFT;
                    end else begin
                        state_s = ST_PRIME;
                    end
                    if (accept_s) begin
                        pref_word_s  = word_data;
                        pref_valid_s = 1'b1;
                        words_s      = words_r + WCNT_ONE;
                    end else begin
                        pref_word_s = pref_word_r;
                    end
                end
            end
            ST_SHIFT: begin
                en_s = 1'b1;
                if (abort || (avail_r == AVAIL_ZERO && !pref_valid_r)) begin
                    // The zero presented here starts the flush with config_en unbroken.
                    data_s       = 1'b0;
                    count_s      = CNT_ZERO;
                    err_s        = 1'b1;
                    state_s      = ST_FLUSH;
                    pref_valid_s = 1'b0;
                    avail_s      = AVAIL_ZERO;
                end else begin
                    count_s = count_r + CNT_ONE;
                    if (avail_r == AVAIL_ZERO) begin
                        data_s       = pref_word_r[WORD_WIDTH-1];
                        shift_word_s = {pref_word_r[WORD_WIDTH-2:0], 1'b0};
                        avail_s      = AVAIL_MOVE;
                        pref_valid_s = 1'b0;
                    end else begin
                        data_s       = shift_word_r[WORD_WIDTH-1];
                        shift_word_s = {shift_word_r[WORD_WIDTH-2:0], 1'b0};
                        avail_s      = avail_r - AVAIL_ONE;
                    end
                    if (count_r == LAST_BIT) begin
                        state_s = ST_LATCH;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                    if (accept_s) begin
                        pref_word_s  = word_data;
                        pref_valid_s = 1'b1;
                        words_s      = words_r + WCNT_ONE;
                    end else begin
                        pref_word_s = pref_word_r;
                    end
                end
            end
            ST_FLUSH: begin
                en_s         = 1'b1;
                data_s       = 1'b0;
                count_s      = count_r + CNT_ONE;
                pref_valid_s = 1'b0;
                if (count_r == LAST_BIT) begin
                    state_s = ST_LATCH;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_LATCH: begin
                done_s       = 1'b1;
                state_s      = ST_IDLE;
                pref_valid_s = 1'b0;
                avail_s      = AVAIL_ZERO;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Registered ready: the slot will be free, or its word moves into the shift word next clock.
        if ((state_s == ST_PRIME || state_s == ST_SHIFT) && (words_s < WORDS_MAX) &&
            (!pref_valid_s || avail_s == AVAIL_ZERO)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge config_clk) begin
        if (config_rst) begin
            state_r      <= ST_IDLE;
            shift_word_r <= {WORD_WIDTH{1'b0}};
            avail_r      <= AVAIL_ZERO;
            pref_word_r  <= {WORD_WIDTH{1'b0}};
            pref_valid_r <= 1'b0;
            words_r      <= WCNT_ZERO;
            data_r       <= 1'b0;
            en_r         <= 1'b0;
            ready_r      <= 1'b0;
            count_r      <= CNT_ZERO;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_word_r <= shift_word_s;
            avail_r      <= avail_s;
            pref_word_r  <= pref_word_s;
            pref_valid_r <= pref_valid_s;
            words_r      <= words_s;
            data_r       <= data_s;
            en_r         <= en_s;
            ready_r      <= ready_s;
            count_r      <= count_s;
            done_r       <= done_s;
            err_r        <= err_s;
        end
    end

    assign word_ready  = ready_r;
    assign config_data = data_r;
    assign config_en   = en_r;
    assign busy        = (state_r != ST_IDLE);
    assign done        = done_r;
    assign err         = err_r;
    assign bit_count   = count_r;

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: 70-bit chain model at the outputs, randomized word
// feeder, and a per-cycle checker derived from the bitstream the source actually handed over.
module tb_config_loader;

    localparam int WW = 32;
    localparam int CL = 70;
    localparam int CW = $clog2(CL + 1);
    localparam int NW = (CL + WW - 1) / WW;

    logic          config_clk = 1'b0;
    logic          config_rst;
    logic          start;
    logic          abort;
    logic [WW-1:0] word_data;
    logic          word_valid;
    logic          word_ready;
    logic          config_data;
    logic          config_en;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] bit_count;

    config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL)) dut (
        .config_clk (config_clk),
        .config_rst (config_rst),
        .start      (start),
        .abort      (abort),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .config_data(config_data),
        .config_en  (config_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bit_count  (bit_count)
    );

    always #5 config_clk = ~config_clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model state (written only by the checker process)
    logic [CL-1:0] chain = '0;
    logic [CL-1:0] mem   = '0;
    logic [WW-1:0] stream[$];
    logic          flushing   = 1'b0;
    logic          prev_en    = 1'b0;
    logic          start_pend = 1'b0;
    logic          rst_seen   = 1'b0;
    int            prev_cnt   = 0;
    int            last_clean = 0;
    int            run_len    = 0;
    int            zero_run   = 0;

    // Feeder state
    logic [WW-1:0] feed_q[$];
    int            gap_max = 0;
    logic          hold    = 1'b0;

    function automatic logic [CL-1:0] exp_mem(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                              input logic [WW-1:0] c);
        logic [3*WW-1:0] cat;
        cat = {a, b, c};
        return cat[3*WW-1 -: CL];
    endfunction

    initial begin
        forever begin
            @(posedge config_clk);
            rst_seen = config_rst;
        end
    end

    // Word source with random inter-word gaps
    initial begin
        logic took;
        int   gap;
        gap = 0;
        word_valid = 1'b0;
        word_data  = '0;
        forever begin
            @(negedge config_clk);
            took = word_valid && word_ready;
            @(posedge config_clk);
            #1;
            if (took && feed_q.size() > 0) begin
                void'(feed_q.pop_front());
                gap = $urandom_range(0, gap_max);
            end
            if (gap > 0) begin
                gap--;
                word_valid = 1'b0;
            end else if (!hold && feed_q.size() > 0) begin
                word_valid = 1'b1;
                word_data  = feed_q[0];
            end else begin
                word_valid = 1'b0;
            end
        end
    end

    // Per-cycle compare against the chain model and accepted bitstream
    initial begin
        int idx;
        forever begin
            @(negedge config_clk);
            if (rst_seen) begin
                chk("rst_en", config_en, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_ready", word_ready, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_err", err, 1'b0);
                chk("rst_cnt", bit_count, 0);
                if (prev_en) mem = chain;
                flushing = 1'b0;
                stream.delete();
                run_len  = 0;
                prev_en  = 1'b0;
                prev_cnt = 0;
                start_pend = 1'b0;
            end else begin
                if (start_pend) begin
                    chk("start_done_clr", done, 1'b0);
                    chk("start_err_clr", err, 1'b0);
                    chk("start_busy", busy, 1'b1);
                    chk("start_cnt", bit_count, 0);
                    start_pend = 1'b0;
                end
                if (!busy) begin
                    chk("idle_en", config_en, 1'b0);
                    chk("idle_ready", word_ready, 1'b0);
                end
                if (start && !busy) begin
                    stream.delete();
                    flushing   = 1'b0;
                    run_len    = 0;
                    start_pend = 1'b1;
                end
                if (word_valid && word_ready) begin
                    stream.push_back(word_data);
                    chk("words_le_needed", stream.size() <= NW, 1'b1);
                end
                if (config_en) begin
                    run_len++;
                    if (flushing) begin
                        chk("flush_data", config_data, 1'b0);
                        chk("flush_cnt", bit_count, prev_cnt + 1);
                        zero_run++;
                    end else if (bit_count == 0) begin
                        flushing   = 1'b1;
                        last_clean = prev_cnt;
                        zero_run   = 1;
                        chk("restart_data", config_data, 1'b0);
                    end else begin
                        chk("bit_count", bit_count, prev_cnt + 1);
                        idx = int'(bit_count) - 1;
                        chk("bit_available", idx < stream.size() * WW, 1'b1);
                        if (idx < stream.size() * WW)
                            chk("data", config_data, stream[idx / WW][WW - 1 - (idx % WW)]);
                    end
                    chain = {chain[CL-2:0], config_data};
                end else if (prev_en) begin
                    mem = chain;
                    chk("done_at_fall", done, 1'b1);
                    chk("busy_at_fall", busy, 1'b0);
                    chk("err_at_fall", err, flushing);
                    chk("final_count", bit_count, CL);
                    if (flushing) begin
                        chk("flush_zeros", zero_run >= CL, 1'b1);
                    end else begin
                        chk("en_run", run_len, CL);
                        chk("words_used", stream.size(), NW);
                    end
                    run_len = 0;
                end
                prev_en  = config_en;
                prev_cnt = int'(bit_count);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge config_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        @(negedge config_clk);
        while (!(done && !busy) && k < 600) begin
            @(negedge config_clk);
            k++;
        end
        chk({name, "_timeout"}, k < 600, 1'b1);
        cyc(1);
    endtask

    task automatic wait_cnt(input int v, input string name);
        int k;
        k = 0;
        @(negedge config_clk);
        while (!(config_en && bit_count == v) && k < 400) begin
            @(negedge config_clk);
            k++;
        end
        chk({name, "_timeout"}, k < 400, 1'b1);
    endtask

    task automatic clean_load(input string name, input logic [WW-1:0] a, input logic [WW-1:0] b,
                              input logic [WW-1:0] c, input int gap);
        gap_max = gap;
        feed_q.delete();
        feed_q.push_back(a);
        feed_q.push_back(b);
        feed_q.push_back(c);
        pulse_start();
        wait_done(name);
        chk({name, "_mem"}, mem, exp_mem(a, b, c));
        chk({name, "_err"}, err, 1'b0);
        chk({name, "_done"}, done, 1'b1);
    endtask

    initial begin
        logic [WW-1:0] w0, w1, w2;
        config_rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cyc(3);
        chk("reset_en", config_en, 1'b0);
        chk("reset_ready", word_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_data", config_data, 1'b0);
        config_rst = 1'b0;
        cyc(2);

        // Clean load and partial final word
        clean_load("clean", 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFC000000, 0);
        chk("clean_mem_lit", mem, {32'hA5A5A5A5, 32'h0F0F0F0F, 6'b111111});
        chk("clean_cnt", bit_count, 7'd70);
        chk("clean_words", stream.size(), 3);
        clean_load("partial", 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFFFFFF, 0);
        chk("partial_mem_lit", mem, {32'hA5A5A5A5, 32'h0F0F0F0F, 6'b111111});

        // Source backpressure during PRIME
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        feed_q.delete();
        feed_q.push_back(w0); feed_q.push_back(w1); feed_q.push_back(w2);
        hold = 1'b1;
        pulse_start();
        repeat (10) begin
            @(negedge config_clk);
            chk("bp_en_low", config_en, 1'b0);
        end
        cyc(1);
        hold = 1'b0;
        wait_done("bp");
        chk("bp_mem", mem, exp_mem(w0, w1, w2));
        chk("bp_err", err, 1'b0);

        // Underrun: only the first word is ever offered
        w0 = $urandom;
        feed_q.delete();
        feed_q.push_back(w0);
        pulse_start();
        wait_done("underrun");
        chk("underrun_err", err, 1'b1);
        chk("underrun_done", done, 1'b1);
        chk("underrun_mem", mem, {CL{1'b0}});
        chk("underrun_at", last_clean, 32);
        feed_q.delete();

        // Abort at bit 40, start during flush ignored, then clean reload
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        feed_q.push_back(w0); feed_q.push_back(w1); feed_q.push_back(w2);
        pulse_start();
        wait_cnt(40, "abort_wait");
        #1 abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        wait_cnt(10, "flush_wait");
        #1 start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_done("abort");
        chk("abort_err", err, 1'b1);
        chk("abort_mem", mem, {CL{1'b0}});
        chk("abort_at", last_clean, 40);
        feed_q.delete();
        clean_load("reload", $urandom, $urandom, $urandom, 2);

        // Reset at bit 20: chain latches the first 20 bits of the first word
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        feed_q.delete();
        feed_q.push_back(w0); feed_q.push_back(w1); feed_q.push_back(w2);
        pulse_start();
        wait_cnt(20, "rst_wait");
        #1 config_rst = 1'b1;
        cyc(1);
        config_rst = 1'b0;
        feed_q.delete();
        cyc(1);
        chk("rst_partial_mem", mem[19:0], w0[31:12]);
        chk("rst_after_done", done, 1'b0);
        clean_load("post_rst", $urandom, $urandom, $urandom, 1);

        // Randomized clean loads with random source gaps
        for (int i = 0; i < 4; i++) begin
            clean_load("rand", $urandom, $urandom, $urandom, $urandom_range(0, 6));
        end

        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
